// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Optional build macro: MEM_TIMEOUT_EN (see mem_access_stage.sv).
package mem_access_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // Stall counter stops here instead of wrapping back to zero.
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_mem_wait_watchdog.sv
// Wait-cycle watchdog for the memory stage: counts BUSY cycles and aborts an
// access that has gone unacknowledged for TIMEOUT_CYC cycles. The error flag
// is sticky until reset. Instantiated only when MEM_TIMEOUT_EN is defined.
module mem_wait_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_abort,
  output logic o_err
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign o_abort = i_busy & ~i_ack & (r_cnt == LAST_CNT);
  assign o_err   = r_err;

  // Held at zero outside BUSY, so every entry into BUSY starts from zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (!i_busy || o_abort) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (o_abort) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage pipeline: drives the data-memory req/ack port
// from EX/MEM, stalls upstream until the ack, and registers MEM/WB.
// Optional build macro: MEM_TIMEOUT_EN adds a wait watchdog that aborts an
// unacknowledged access after TIMEOUT_CYC cycles and raises a sticky err_o.
//
// state | meaning
// IDLE  | no access outstanding; zero-wait acks complete here
// BUSY  | access issued, waiting for mem_ack_i
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ALU_Res_i,
  input  logic [DATA_W-1:0] Write_Data_i,
  input  logic [REG_AW-1:0] RdAddr_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ALU_Res_o,
  output logic [DATA_W-1:0] Mem_Data_o,
  output logic [REG_AW-1:0] RdAddr_o,
  output logic              MemToReg_o,
  output logic              RegWrite_o,
  output logic [31:0]       stall_cnt_o,
  output logic              err_o
);

  mem_state_e r_state;
  mem_state_e w_state_nxt;
  logic       w_acc;
  logic       w_abort;
  logic       w_stall;
  logic       w_load_done;

  assign w_acc = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  mem_wait_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_busy (r_state == ST_BUSY),
    .i_ack  (mem_ack_i),
    .o_abort(w_abort),
    .o_err  (err_o)
  );
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Gated by reset so the request and the stall drop the moment reset asserts,
  // not at the next edge; an aborted access also withdraws its request.
  assign mem_req_o   = rst_i & w_acc & ~w_abort;
  assign w_stall     = rst_i & w_acc & ~mem_ack_i & ~w_abort;
  assign stall_o     = w_stall;
  assign mem_we_o    = MemWrite_i;
  assign mem_addr_o  = ALU_Res_i;
  assign mem_wdata_o = Write_Data_i;

  // A store with MemRead also set is still a store: no load data captured.
  assign w_load_done = MemRead_i & ~MemWrite_i & mem_ack_i;

  // Next-state logic for the access FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc && !mem_ack_i) w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ack_i || w_abort) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALU_Res_o  <= '0;
      Mem_Data_o <= '0;
      RdAddr_o   <= '0;
      MemToReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
    end else if (w_stall || w_abort) begin
      RdAddr_o   <= '0;
      MemToReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
    end else begin
      ALU_Res_o  <= ALU_Res_i;
      RdAddr_o   <= RdAddr_i;
      MemToReg_o <= MemToReg_i;
      RegWrite_o <= RegWrite_i;
      if (w_load_done) Mem_Data_o <= mem_rdata_i;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (w_stall && stall_cnt_o != STALL_CNT_MAX) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Transactions are described as
// (controls, address, data, ack delay) and the expected port and MEM/WB values
// are derived per cycle from the stage's rules. Build with MEM_TIMEOUT_EN
// defined to also exercise the watchdog abort path.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [DW-1:0] ALU_Res_i = '0;
  logic [DW-1:0] Write_Data_i = '0;
  logic [AW-1:0] RdAddr_i = '0;
  logic          MemToReg_i = 1'b0;
  logic          RegWrite_i = 1'b0;
  logic          MemWrite_i = 1'b0;
  logic          MemRead_i = 1'b0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_req_o, mem_we_o, stall_o, MemToReg_o, RegWrite_o, err_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o, ALU_Res_o, Mem_Data_o;
  logic [AW-1:0] RdAddr_o;
  logic [31:0]   stall_cnt_o;

  mem_access_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ALU_Res_i(ALU_Res_i), .Write_Data_i(Write_Data_i), .RdAddr_i(RdAddr_i),
    .MemToReg_i(MemToReg_i), .RegWrite_i(RegWrite_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .ALU_Res_o(ALU_Res_o), .Mem_Data_o(Mem_Data_o),
    .RdAddr_o(RdAddr_o), .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_alu, exp_mdata, exp_scnt;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_m2r, exp_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_alu = '0; exp_mdata = '0; exp_scnt = '0; exp_rd = '0;
    exp_rw = 1'b0; exp_m2r = 1'b0; exp_err = 1'b0;
  endtask

  task automatic check_mewb(input string tag);
    check_val({tag, ".alu"},   ALU_Res_o,         exp_alu);
    check_val({tag, ".mdata"}, Mem_Data_o,        exp_mdata);
    check_val({tag, ".rd"},    32'(RdAddr_o),     32'(exp_rd));
    check_val({tag, ".rw"},    32'(RegWrite_o),   32'(exp_rw));
    check_val({tag, ".m2r"},   32'(MemToReg_o),   32'(exp_m2r));
    check_val({tag, ".scnt"},  stall_cnt_o,       exp_scnt);
    check_val({tag, ".err"},   32'(err_o),        32'(exp_err));
  endtask

  task automatic clear_inputs();
    ALU_Res_i = '0; Write_Data_i = '0; RdAddr_i = '0;
    MemToReg_i = 1'b0; RegWrite_i = 1'b0; MemWrite_i = 1'b0; MemRead_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Called at posedge+1. Presents one EX/MEM instruction; if it accesses
  // memory the ack arrives d cycles later (d=0: same cycle). For non-access
  // instructions the pulse at cycle d is a spurious ack.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic m2r, input logic rw, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rdad,
                         input int d, input logic [31:0] rdata);
    logic acc;
    acc = rd | wr;
    ALU_Res_i = alu; Write_Data_i = wd; RdAddr_i = rdad;
    MemToReg_i = m2r; RegWrite_i = rw; MemWrite_i = wr; MemRead_i = rd;
    for (int k = 0; k <= d; k++) begin
      mem_ack_i   = (k == d);
      mem_rdata_i = (k == d) ? rdata : $urandom;
      #1;
      check_val({tag, ".req"},   32'(mem_req_o), 32'(acc));
      check_val({tag, ".we"},    32'(mem_we_o),  32'(wr));
      check_val({tag, ".addr"},  mem_addr_o,     alu);
      check_val({tag, ".wdata"}, mem_wdata_o,    wd);
      check_val({tag, ".stall"}, 32'(stall_o),   32'(acc && (k < d)));
      @(posedge clk_i); #1;
      if (acc && (k < d)) begin
        exp_rw = 1'b0; exp_m2r = 1'b0; exp_rd = '0;
        if (exp_scnt != 32'hFFFF_FFFF) exp_scnt = exp_scnt + 1;
      end else begin
        exp_alu = alu; exp_rd = rdad; exp_rw = rw; exp_m2r = m2r;
        if (rd && !wr && (k == d)) exp_mdata = rdata;
      end
      check_mewb(tag);
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    // Reset held with random inputs, including a live request and ack.
    for (int i = 0; i < 4; i++) begin
      ALU_Res_i = $urandom; Write_Data_i = $urandom; RdAddr_i = 5'($urandom);
      MemToReg_i = 1'b1; RegWrite_i = 1'b1; MemRead_i = 1'b1;
      MemWrite_i = 1'($urandom); mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
      @(posedge clk_i); #1;
      check_val("rst.req",   32'(mem_req_o), 32'd0);
      check_val("rst.stall", 32'(stall_o),   32'd0);
      check_mewb("rst");
    end
    clear_inputs();
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_mewb("rel");

    // Non-access: MEM/WB follows inputs one edge later.
    run_txn("idle", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 32'h3, 5'd9, 0, 32'h0);
    // Load x5 from 0x40 with a zero-wait ack.
    run_txn("ld0", 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);
    check_val("ld0.final", Mem_Data_o, 32'hDEAD_BEEF);
    // Store 0x1234 to 0x80 with ack after 3 cycles.
    run_txn("st3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234, 5'd0, 3, 32'h0);
    check_val("st3.scnt", stall_cnt_o, 32'd3);
    // Spurious ack while idle must not touch Mem_Data_o.
    run_txn("spur", 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h6, 5'd7, 0, 32'hFFFF_FFFF);
    check_val("spur.mdata", Mem_Data_o, 32'hDEAD_BEEF);
    // Read+write together behaves as a store.
    run_txn("rdwr", 1'b1, 1'b1, 1'b0, 1'b0, 32'h90, 32'hABCD, 5'd3, 1, 32'h5555_AAAA);

    // Randomized mix of loads, stores and plain ALU ops.
    for (int i = 0; i < 60; i++) begin
      logic rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      run_txn("rnd", rd, wr, 1'($urandom), 1'($urandom), $urandom, $urandom,
              5'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    // Reset in the middle of a waiting load.
    ALU_Res_i = 32'h100; RdAddr_i = 5'd12; MemRead_i = 1'b1; MemToReg_i = 1'b1;
    RegWrite_i = 1'b1; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    model_reset();
    check_val("midrst.req",   32'(mem_req_o), 32'd0);
    check_val("midrst.stall", 32'(stall_o),   32'd0);
    check_mewb("midrst");
    clear_inputs();
    @(posedge clk_i); #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_mewb("midrst.rel");
    run_txn("post", 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd4, 2, 32'hCAFE_F00D);

`ifdef MEM_TIMEOUT_EN
    // Load that is never acknowledged: aborted after TO cycles.
    ALU_Res_i = 32'h300; RdAddr_i = 5'd6; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    MemToReg_i = 1'b1; RegWrite_i = 1'b1; mem_ack_i = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      #1;
      check_val("to.stall", 32'(stall_o), 32'(k < TO));
      @(posedge clk_i); #1;
      exp_rw = 1'b0; exp_m2r = 1'b0; exp_rd = '0;
      if (k < TO) exp_scnt = exp_scnt + 1;
      else        exp_err  = 1'b1;
      check_mewb("to");
    end
    // Late ack after the abort, pipeline has moved on to a non-access op.
    clear_inputs();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check_val("late.stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    exp_alu = '0;
    check_mewb("late");
    mem_ack_i = 1'b0;
    run_txn("to.after", 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd8, 1, 32'h0BAD_CAFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
